// File: rtl/sram_ctrl_wide.sv
// Wide-access controller for a 16-bit asynchronous SRAM: each DATA_W load/store is split into
// DATA_W/16 half-word beats of 1+WAIT_CYC cycles. Optional byte masking via SRAM_CTRL_BYTE_MASK_EN.
module sram_ctrl_wide #(
  parameter int DATA_W   = 32,
  parameter int SRAM_AW  = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [31:0]           address,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     readData,
  output logic                  ready,
  inout  wire  [15:0]           SRAM_DQ,
  output logic [SRAM_AW-1:0]    SRAM_ADDR,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N
);
  localparam int BEATS = DATA_W / 16;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] BMASK = 32'((BEATS > 1) ? ((1 << $clog2(BEATS)) - 1) : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [BCW-1:0]      beat_q, beat_d;
  logic [2:0]          wait_q, wait_d;
  logic                wr_q, wr_d;
  logic [30:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [DATA_W/8-1:0] be_q, be_d;
`else
  logic                unused_be;
  assign unused_be = &{1'b0, byte_en};
`endif
  logic                unused_addr;
  assign unused_addr = &{1'b0, address[0]};

  logic        req, last_cyc, last_beat, dq_oe;
  logic [15:0] dq_out;

  assign req       = wr_en | rd_en;
  assign last_cyc  = (wait_q == 3'(WAIT_CYC));
  assign last_beat = (beat_q == BCW'(BEATS - 1));
  assign readData  = rdata_q;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_CTRL_BYTE_MASK_EN
      be_q    <= be_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_BYTE_MASK_EN
    be_d    = be_q;
`endif
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !req;
        if (req) begin
          wr_d    = wr_en;  // write wins when both are requested
          addr_d  = address[31:1];
          wdata_d = writeData;
`ifdef SRAM_CTRL_BYTE_MASK_EN
          be_d    = byte_en;
`endif
          beat_d  = '0;
          wait_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A dropped request abandons the access; abort takes precedence over a capture.
        if (!req) begin
          state_d = IDLE;
          beat_d  = '0;
          wait_d  = '0;
        end else if (last_cyc) begin
          if (!wr_q) rdata_d[{beat_q, 4'b0000} +: 16] = SRAM_DQ;
          wait_d = '0;
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[{beat_q, 4'b0000} +: 16];
    if (state_q == ACCESS) begin
      SRAM_CE_N = 1'b0;
      SRAM_ADDR = SRAM_AW'(({1'b0, addr_q} & ~BMASK) | 32'(beat_q));
      if (wr_q) begin
        dq_oe     = 1'b1;
        SRAM_WE_N = !last_cyc;  // strobe only after the setup cycles of the beat
`ifdef SRAM_CTRL_BYTE_MASK_EN
        SRAM_UB_N = ~be_q[{beat_q, 1'b1}];
        SRAM_LB_N = ~be_q[{beat_q, 1'b0}];
`else
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
`endif
      end else begin
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
    end
  end
endmodule

// File: doc/sram_ctrl_wide.md
# sram_ctrl_wide

Parametrised SRAM controller between the memory stage and the external 16-bit asynchronous SRAM. It splits each DATA_W-bit load or store into DATA_W/16 sequential half-word beats and inserts WAIT_CYC wait cycles per beat. Writes support per-byte masking. `ready` freezes the pipeline while an access is in flight.

## Interface
- DATA_W, 32: access width; multiple of 16 in the range 16..128; BEATS = DATA_W/16.
- SRAM_AW, 18: SRAM address width.
- WAIT_CYC, 1: extra cycles per beat, 0..7.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  store request; level, held until `ready`=1.
- rd_en  in  1  load request; level, held until `ready`=1.
- address  in  32  byte address; bits [log2(DATA_W/8)-1:0] ignored.
- writeData  in  DATA_W  store data.
- byte_en  in  DATA_W/8  store byte mask; bit i covers writeData[8i+7:8i].
- readData  out  DATA_W  registered load result.
- ready  out  1  1 = no access pending or access completing this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  SRAM strobes, active-low.

## Operation
- States: IDLE, ACCESS, DONE. A beat counter (0..BEATS-1) and a wait counter (0..WAIT_CYC) run in ACCESS.
- IDLE:
  - If wr_en|rd_en, latch address, writeData, byte_en and the op, then go to ACCESS.
  - If both wr_en and rd_en are high, the write wins.
  - ready = !(wr_en|rd_en), combinational.
- ACCESS:
  - SRAM_ADDR = {address word index, beat}, truncated to SRAM_AW.
  - Beat b carries writeData[16b+15:16b]; beat 0 is the low half-word.
  - SRAM_CE_N = 0 throughout. Reads drive SRAM_OE_N = 0 and release SRAM_DQ (Z).
  - Writes drive SRAM_DQ, and drive SRAM_WE_N = 0 only on the last cycle of each beat (wait counter == WAIT_CYC).
  - UB_N/LB_N for writes = ~byte_en[2b+1], ~byte_en[2b]. Both are 0 for reads.
  - Reads capture SRAM_DQ into readData[16b+15:16b] at the edge ending the beat's last cycle.
  - After the last cycle of beat BEATS-1, go to DONE. ready = 0.
- DONE: ready = 1, strobes inactive, SRAM_DQ = Z; go to IDLE unconditionally.
- Abort: if wr_en and rd_en are both low at an edge in ACCESS, go to IDLE. Beats already written stay written; readData keeps its partially updated value.
- readData changes only on read captures. Writes never modify it.
- A beat with both byte_en bits 0 still spends its cycles, with UB_N = LB_N = 1.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, counters 0, readData 0.
  - SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N all 1.
  - SRAM_DQ = Z, SRAM_ADDR = 0.
  - ready = 1 when no request is present.
- Reset asserted mid-access aborts at once: strobes high and DQ released in the same cycle. No partial beat completes.
- Latency: the request is seen in IDLE at cycle 0; ready = 1 in cycle 1 + BEATS*(1+WAIT_CYC). Defaults give cycle 5.
- Back-to-back requests: a request still high in the cycle after DONE is accepted from IDLE. Minimum spacing is 2 + BEATS*(1+WAIT_CYC) cycles.
- SRAM_ADDR, DQ drive and UB/LB are stable for every cycle of a beat. With WAIT_CYC ≥ 1, this gives at least one cycle of address and data setup before WE_N falls.
- The memory stage must keep address/data stable until ready = 1. The block uses latched copies regardless.

## Configuration
- SRAM_CTRL_BYTE_MASK_EN defined: byte_en controls UB_N/LB_N on writes as described above.
- Undefined: byte_en is ignored. Every write beat drives UB_N = LB_N = 0 (full-word stores only); the port remains for interface compatibility.
- Read behaviour is identical in both builds.

## Test plan
- Defaults, reset then write 0xDEADBEEF to address 0x100 with byte_en = 0xF:
  - SRAM_ADDR 0x080 with DQ 0xBEEF, then SRAM_ADDR 0x081 with DQ 0xDEAD.
  - One WE_N pulse per beat; ready = 1 at cycle 5.
- Read back address 0x100 from an SRAM model: readData = 0xDEADBEEF when ready = 1 at cycle 5; OE_N = 0 for cycles 1-4.
- With SRAM_CTRL_BYTE_MASK_EN, write 0x11223344 with byte_en = 0x6:
  - Beat 0: UB_N = 0, LB_N = 1. Beat 1: UB_N = 1, LB_N = 0.
  - Readback over prior 0xDEADBEEF = 0xDE2233EF.
  - Without the macro, readback = 0x11223344.
- DATA_W = 64, WAIT_CYC = 0, read address 0x8:
  - 4 beats at SRAM_ADDR 0x4..0x7; ready at cycle 5.
  - readData = {beat3, beat2, beat1, beat0}.
- wr_en and rd_en both high on the same cycle: a write is performed and OE_N stays 1.
- rst_n pulled low in cycle 2 of a write: all strobes return to 1 and DQ goes Z in that cycle. After release, ready = 1 and state is IDLE.
